// File: rtl/regfile_pkg.sv
// Shared register-file constants and types: index width, zero-register index, word type.
package regfile_pkg;
    localparam int          REG_ADDR_W = 5;
    localparam logic [4:0]  ZERO_REG   = 5'd31;
    typedef logic [63:0] word_t;
endpackage

// File: rtl/decoder_5to32.sv
// One-hot write-enable decode gated by en; the zero-register bit never asserts.
// Combinational, no backpressure.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] sel,
    input  logic                  en,
    output logic [31:0]           onehot
);

    always_comb begin
        onehot = '0;
        if (en && (sel != ZERO_REG)) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_cell.sv
// Enabled storage cell: one register with synchronous clear.
// Loads d on the clock edge after en=1; no backpressure.
module regfile_cell #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_32x64.sv
// 32-entry register file, two combinational read ports, one write port, X31 hardwired to 0.
// Write visible one edge later (same cycle when BYPASS=1); never stalls.
module regfile_32x64
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 32,
    parameter int BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]      WriteData,
    input  logic [REG_ADDR_W-1:0] ReadRegister1,
    input  logic [REG_ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]      ReadData1,
    output logic [WIDTH-1:0]      ReadData2
);

    logic [31:0]      wr_en;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] mux1;
    logic [WIDTH-1:0] mux2;

    decoder_5to32 u_dec (
        .sel    (WriteRegister),
        .en     (RegWrite),
        .onehot (wr_en)
    );

    // The last entry has no storage; it is the constant-zero input of both muxes.
    for (genvar i = 0; i < NREGS - 1; i++) begin : g_cell
        regfile_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en[i]),
            .d     (WriteData),
            .q     (regs[i])
        );
    end
    assign regs[NREGS-1] = '0;

    assign mux1 = regs[ReadRegister1];
    assign mux2 = regs[ReadRegister2];

    if (BYPASS != 0) begin : g_bypass
        logic hit1;
        logic hit2;
        assign hit1 = !reset && RegWrite && (WriteRegister == ReadRegister1)
                      && (ReadRegister1 != ZERO_REG);
        assign hit2 = !reset && RegWrite && (WriteRegister == ReadRegister2)
                      && (ReadRegister2 != ZERO_REG);
        assign ReadData1 = hit1 ? WriteData : mux1;
        assign ReadData2 = hit2 ? WriteData : mux2;
    end else begin : g_no_bypass
        assign ReadData1 = mux1;
        assign ReadData2 = mux2;
    end

endmodule

// File: tb/tb_regfile_32x64.sv
// Scoreboard bench for regfile_32x64, exercising BYPASS=0 and BYPASS=1 instances side by side.
module tb_regfile_32x64;
    import regfile_pkg::*;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    word_t       WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    word_t       rd1_n, rd2_n, rd1_b, rd2_b;

    int checks   = 0;
    int failures = 0;

    word_t model [32];
    word_t sb_q [$];

    regfile_32x64 #(.WIDTH(64), .NREGS(32), .BYPASS(0)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (rd1_n),
        .ReadData2     (rd2_n)
    );

    regfile_32x64 #(.WIDTH(64), .NREGS(32), .BYPASS(1)) dut_byp (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (rd1_b),
        .ReadData2     (rd2_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t exp_plain(input logic [4:0] idx);
        return (idx == 5'd31) ? 64'h0 : model[idx];
    endfunction

    function automatic word_t exp_byp(input logic [4:0] idx);
        if (!reset && RegWrite && WriteRegister == idx && idx != 5'd31)
            return WriteData;
        return exp_plain(idx);
    endfunction

    // Queue expected values for the current read indices in port order n1, n2, b1, b2.
    task automatic push_exp();
        sb_q.push_back(exp_plain(ReadRegister1));
        sb_q.push_back(exp_plain(ReadRegister2));
        sb_q.push_back(exp_byp(ReadRegister1));
        sb_q.push_back(exp_byp(ReadRegister2));
    endtask

    // Apply one rising edge to the model, then return to the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < 32; r++) model[r] = 64'h0;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model[WriteRegister] = WriteData;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                         input word_t wd, input logic [4:0] ra, input logic [4:0] rb);
        reset = rst; RegWrite = we; WriteRegister = wr; WriteData = wd;
        ReadRegister1 = ra; ReadRegister2 = rb;
    endtask

    task automatic test_reset();
        word_t act [4];
        word_t e;
        drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            push_exp();
            #1;
            act = '{rd1_n, rd2_n, rd1_b, rd2_b};
            for (int k = 0; k < 4; k++) begin
                e = sb_q.pop_front();
                checks++;
                if (act[k] !== e || e !== 64'h0) begin
                    failures++;
                    $display("FAIL reset idx=%0d port=%0d got=%h exp=%h", i, k, act[k], 64'h0);
                end
            end
        end
    endtask

    task automatic test_write();
        word_t act [4];
        word_t e;
        drive(1'b0, 1'b1, 5'd5, 64'h00A0000000FFF000, 5'd0, 5'd0);
        tick();
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'd5;
            ReadRegister2 = 5'(i);
            push_exp();
            #1;
            act = '{rd1_n, rd2_n, rd1_b, rd2_b};
            for (int k = 0; k < 4; k++) begin
                e = sb_q.pop_front();
                checks++;
                if (act[k] !== e) begin
                    failures++;
                    $display("FAIL write_x5 rd2=%0d port=%0d got=%h exp=%h", i, k, act[k], e);
                end
            end
        end
    endtask

    task automatic test_no_write();
        word_t act [4];
        word_t e;
        drive(1'b0, 1'b0, 5'd5, 64'hDEAD, 5'd5, 5'd5);
        tick();
        push_exp();
        #1;
        act = '{rd1_n, rd2_n, rd1_b, rd2_b};
        for (int k = 0; k < 4; k++) begin
            e = sb_q.pop_front();
            checks++;
            if (act[k] !== e || e !== 64'h00A0000000FFF000) begin
                failures++;
                $display("FAIL regwrite_low port=%0d got=%h exp=%h", k, act[k], 64'h00A0000000FFF000);
            end
        end
    endtask

    task automatic test_x31();
        word_t act [4];
        word_t e;
        drive(1'b0, 1'b1, 5'd31, 64'hFFFFFFFFFFFFFFFF, 5'd31, 5'd31);
        for (int ph = 0; ph < 2; ph++) begin
            push_exp();
            #1;
            act = '{rd1_n, rd2_n, rd1_b, rd2_b};
            for (int k = 0; k < 4; k++) begin
                e = sb_q.pop_front();
                checks++;
                if (act[k] !== e || e !== 64'h0) begin
                    failures++;
                    $display("FAIL x31 phase=%0d port=%0d got=%h exp=%h", ph, k, act[k], 64'h0);
                end
            end
            if (ph == 0) tick();
        end
        RegWrite = 1'b0;
    endtask

    task automatic test_same_cycle();
        word_t act [4];
        word_t e;
        drive(1'b0, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd7);
        push_exp();
        #1;
        act = '{rd1_n, rd2_n, rd1_b, rd2_b};
        for (int k = 0; k < 4; k++) begin
            e = sb_q.pop_front();
            checks++;
            if (act[k] !== e) begin
                failures++;
                $display("FAIL rdw_before port=%0d got=%h exp=%h", k, act[k], e);
            end
        end
        tick();
        RegWrite = 1'b0;
        push_exp();
        #1;
        act = '{rd1_n, rd2_n, rd1_b, rd2_b};
        for (int k = 0; k < 4; k++) begin
            e = sb_q.pop_front();
            checks++;
            if (act[k] !== e || e !== 64'h1234) begin
                failures++;
                $display("FAIL rdw_after port=%0d got=%h exp=%h", k, act[k], 64'h1234);
            end
        end
    endtask

    task automatic test_reset_priority();
        word_t act [4];
        word_t e;
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 1'b1, 5'(i), 64'(i + 1), 5'd0, 5'd0);
            tick();
        end
        // Reset with a colliding write: bypass must not forward while reset is high.
        drive(1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd30);
        push_exp();
        #1;
        act = '{rd1_n, rd2_n, rd1_b, rd2_b};
        for (int k = 0; k < 4; k++) begin
            e = sb_q.pop_front();
            checks++;
            if (act[k] !== e) begin
                failures++;
                $display("FAIL rst_filled port=%0d got=%h exp=%h", k, act[k], e);
            end
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            push_exp();
            #1;
            act = '{rd1_n, rd2_n, rd1_b, rd2_b};
            for (int k = 0; k < 4; k++) begin
                e = sb_q.pop_front();
                checks++;
                if (act[k] !== e || e !== 64'h0) begin
                    failures++;
                    $display("FAIL rst_priority idx=%0d port=%0d got=%h exp=%h", i, k, act[k], 64'h0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        word_t act [4];
        word_t e;
        for (int n = 0; n < 300; n++) begin
            drive(1'b0, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) ReadRegister1 = WriteRegister;
            push_exp();
            #1;
            act = '{rd1_n, rd2_n, rd1_b, rd2_b};
            for (int k = 0; k < 4; k++) begin
                e = sb_q.pop_front();
                checks++;
                if (act[k] !== e) begin
                    failures++;
                    $display("FAIL b2b n=%0d port=%0d got=%h exp=%h", n, k, act[k], e);
                end
            end
            tick();
        end
        RegWrite = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        for (int r = 0; r < 32; r++) model[r] = 64'h0;
        @(negedge clk);
        test_reset();
        test_write();
        test_no_write();
        test_x31();
        test_same_cycle();
        test_reset_priority();
        test_back_to_back();
        checks++;
        if (sb_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=%0d", sb_q.size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
